// File: rtl/fpdiv_sched.sv
// fpdiv_sched: round-robin scheduler and sequencer for the shared iterative fp32 divider
module fpdiv_sched #(
   parameter int ITERS   = 4,
   parameter int MUL_LAT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [63:0] req_dividend,
   input  logic [63:0] req_divisor,
   input  logic [3:0]  req_round_mode,
   output logic [1:0]  rsp_valid,
   input  logic [1:0]  rsp_ready,
   output logic [31:0] rsp_quotient,
   output logic        busy,
   output logic        dp_load,
   output logic [31:0] dp_n,
   output logic [31:0] dp_d,
   output logic [1:0]  dp_rm,
   output logic        dp_step,
   output logic        dp_round,
   input  logic [31:0] dp_q
);
   typedef enum logic [2:0] {IDLE, LOAD, ITER, ROUND, RESP} state_t;
   localparam logic [2:0] CYC_LAST  = 3'(MUL_LAT - 1);
   localparam logic [3:0] ITER_LAST = 4'(ITERS - 1);
   state_t state, state_nxt;
   logic g, owner, last_grant, cyc_last;
   logic [2:0] cyc;
   logic [3:0] iter;
   assign g = (&req_valid) ? ~last_grant : req_valid[1];
   assign cyc_last = cyc == CYC_LAST;
   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else state <= state_nxt;
   end
   // next state, handshakes and datapath strobes
   always_comb begin
      state_nxt = state;
      req_ready = 2'b00;
      rsp_valid = 2'b00;
      busy = state != IDLE;
      dp_load = state == LOAD;
      dp_step = state == ITER && cyc == 3'd0;
      dp_round = state == ROUND;
      case (state)
         IDLE: begin
            req_ready[g] = 1'b1;
            if (req_valid[g]) state_nxt = LOAD;
         end
         LOAD: state_nxt = ITER;
         ITER: if (cyc_last && iter == ITER_LAST) state_nxt = ROUND;
         ROUND: state_nxt = RESP;
         RESP: begin
            rsp_valid[owner] = 1'b1;
            if (rsp_ready[owner]) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end
   // operand latch, iteration counters, result capture and fairness pointer
   always_ff @(posedge clk) begin
      if (reset) begin
         dp_n <= '0;
         dp_d <= '0;
         dp_rm <= '0;
         owner <= 1'b0;
         last_grant <= 1'b1;
         cyc <= '0;
         iter <= '0;
         rsp_quotient <= '0;
      end else begin
         if (state == IDLE && req_valid[g]) begin
            dp_n <= g ? req_dividend[63:32] : req_dividend[31:0];
            dp_d <= g ? req_divisor[63:32] : req_divisor[31:0];
            dp_rm <= g ? req_round_mode[3:2] : req_round_mode[1:0];
            owner <= g;
         end
         if (state == LOAD) begin
            cyc <= '0;
            iter <= '0;
         end
         if (state == ITER) begin
            cyc <= cyc_last ? 3'd0 : cyc + 3'd1;
            iter <= iter + 4'(cyc_last);
         end
         if (state == ROUND) rsp_quotient <= dp_q;
         if (state == RESP && rsp_ready[owner]) last_grant <= owner;
      end
   end
endmodule

// File: tb/tb_fpdiv_sched.sv
// tb_fpdiv_sched: table-driven and scoreboard checks of the divider scheduler
module tb_fpdiv_sched;
   localparam int ITERS = 4, MUL_LAT = 2, LAT = ITERS * MUL_LAT;
   typedef struct {
      logic [1:0] valid;
      logic exp_g;
      logic fix;
      logic gap;
      int bp;
      logic [31:0] n0, d0, n1, d1;
      logic [1:0] rm0, rm1;
   } vec_t;
   typedef struct {
      logic owner;
      logic [31:0] q;
      logic [1:0] rm;
   } exp_t;
   logic clk = 1'b0, reset = 1'b1, fix_en = 1'b0;
   logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready, dp_rm;
   logic [63:0] req_dividend, req_divisor;
   logic [3:0] req_round_mode;
   logic [31:0] rsp_quotient, dp_n, dp_d, dp_q;
   logic busy, dp_load, dp_step, dp_round;
   logic [1:0] req_valid_1, req_ready_1, rsp_valid_1, rsp_ready_1, dp_rm_1;
   logic [63:0] req_dividend_1, req_divisor_1;
   logic [3:0] req_round_mode_1;
   logic [31:0] rsp_quotient_1, dp_n_1, dp_d_1, dp_q_1;
   logic busy_1, dp_load_1, dp_step_1, dp_round_1;
   int checks = 0, failures = 0, cyc_cnt = 0, last_acc = 0;
   exp_t sb[$];
   vec_t tv[10];

   fpdiv_sched #(.ITERS(ITERS), .MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_dividend(req_dividend), .req_divisor(req_divisor), .req_round_mode(req_round_mode),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_quotient(rsp_quotient), .busy(busy),
      .dp_load(dp_load), .dp_n(dp_n), .dp_d(dp_d), .dp_rm(dp_rm), .dp_step(dp_step),
      .dp_round(dp_round), .dp_q(dp_q)
   );
   fpdiv_sched #(.ITERS(1), .MUL_LAT(1)) dut1 (
      .clk(clk), .reset(reset), .req_valid(req_valid_1), .req_ready(req_ready_1),
      .req_dividend(req_dividend_1), .req_divisor(req_divisor_1), .req_round_mode(req_round_mode_1),
      .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready_1), .rsp_quotient(rsp_quotient_1), .busy(busy_1),
      .dp_load(dp_load_1), .dp_n(dp_n_1), .dp_d(dp_d_1), .dp_rm(dp_rm_1), .dp_step(dp_step_1),
      .dp_round(dp_round_1), .dp_q(dp_q_1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
   // datapath stub: a quotient only in the round cycle, garbage otherwise
   assign dp_q = !dp_round ? 32'hDEAD_BEEF : fix_en ? 32'h3FC0_0000 : dp_n ^ dp_d;
   assign dp_q_1 = !dp_round_1 ? 32'hDEAD_BEEF : dp_n_1 ^ dp_d_1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic [1:0] valid, input logic g, input logic fix,
                               input logic gap, input int bp, input logic [1:0] rm0,
                               input logic [1:0] rm1);
      vec_t v;
      v.valid = valid; v.exp_g = g; v.fix = fix; v.gap = gap; v.bp = bp;
      v.rm0 = rm0; v.rm1 = rm1;
      v.n0 = $urandom; v.d0 = $urandom; v.n1 = $urandom; v.d1 = $urandom;
      return v;
   endfunction

   task automatic do_txn(input vec_t v);
      logic [63:0] st_a, st_e;
      logic [1:0] own_bit;
      int c_load, c_round, c_rsp;
      exp_t e;
      st_a = '0; st_e = '0; c_load = -1; c_round = -1; c_rsp = -1;
      for (int k = 0; k < ITERS; k++) st_e[2 + k * MUL_LAT] = 1'b1;
      own_bit = v.exp_g ? 2'b10 : 2'b01;
      fix_en = v.fix;
      req_dividend = {v.n1, v.n0};
      req_divisor = {v.d1, v.d0};
      req_round_mode = {v.rm1, v.rm0};
      req_valid = v.valid;
      #1;
      chk("grant", req_ready, own_bit);
      e.owner = v.exp_g;
      e.q = v.fix ? 32'h3FC0_0000 : v.exp_g ? v.n1 ^ v.d1 : v.n0 ^ v.d0;
      e.rm = v.exp_g ? v.rm1 : v.rm0;
      tick();
      sb.push_back(e);
      if (v.gap) chk("accept_gap", cyc_cnt - last_acc, 4 + LAT);
      last_acc = cyc_cnt;
      req_valid = 2'b00;
      for (int c = 1; c < 40 && c_rsp < 0; c++) begin
         if (dp_load) c_load = c;
         if (dp_step) st_a[c] = 1'b1;
         if (dp_round) begin
            c_round = c;
            chk("dp_rm", dp_rm, e.rm);
         end
         if (rsp_valid != 2'b00) c_rsp = c;
         else tick();
      end
      chk("load_cycle", c_load, 1);
      chk("step_cycles", st_a, st_e);
      chk("round_cycle", c_round, 2 + LAT);
      chk("rsp_cycle", c_rsp, 3 + LAT);
      chk("sb_size", sb.size(), 1);
      if (sb.size() > 0) e = sb.pop_front();
      chk("rsp_owner", rsp_valid, e.owner ? 2'b10 : 2'b01);
      chk("rsp_quot", rsp_quotient, e.q);
      if (v.bp > 0) begin
         rsp_ready = ~own_bit;
         req_valid = 2'b11;
         for (int i = 0; i < v.bp; i++) begin
            tick();
            chk("bp_valid", rsp_valid, own_bit);
            chk("bp_quot", rsp_quotient, e.q);
            chk("bp_req_ready", req_ready, 2'b00);
         end
      end
      rsp_ready = own_bit;
      tick();
      rsp_ready = 2'b00;
      req_valid = 2'b00;
      chk("post_busy", busy, 0);
      chk("post_rsp_valid", rsp_valid, 2'b00);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not end, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int seen, steps, c_rsp;
      logic [31:0] n, d;
      req_valid = 0; req_dividend = 0; req_divisor = 0; req_round_mode = 0; rsp_ready = 0;
      req_valid_1 = 0; req_dividend_1 = 0; req_divisor_1 = 0; req_round_mode_1 = 0; rsp_ready_1 = 0;
      tv[0] = mk(2'b01, 0, 1, 0, 0, 2'd0, 2'd0);
      tv[0].n0 = 32'h4040_0000;
      tv[0].d0 = 32'h4000_0000;
      tv[1] = mk(2'b11, 1, 0, 1, 0, 2'd1, 2'd2);
      tv[2] = mk(2'b11, 0, 0, 1, 0, 2'd3, 2'd1);
      tv[3] = mk(2'b11, 1, 0, 1, 0, 2'd2, 2'd3);
      tv[4] = mk(2'b10, 1, 0, 1, 5, 2'd0, 2'd1);
      tv[5] = mk(2'b01, 0, 0, 0, 0, 2'd3, 2'd0);
      tv[6] = mk(2'b11, 1, 0, 1, 0, 2'd0, 2'd2);
      tv[7] = mk(2'b01, 0, 0, 1, 0, 2'd1, 2'd0);
      tv[8] = mk(2'b11, 0, 0, 0, 0, 2'd2, 2'd1);
      tv[9] = mk(2'b11, 1, 0, 1, 0, 2'd1, 2'd3);
      repeat (3) @(posedge clk);
      #1;
      reset = 0;
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 2'b00);
      chk("rst_quot", rsp_quotient, 0);
      chk("rst_operands", {dp_n, dp_d}, 0);
      chk("rst_strobes", {dp_rm, dp_load, dp_step, dp_round}, 0);
      req_valid = 2'b11;
      #1;
      chk("rst_tie_grant", req_ready, 2'b01);
      req_valid = 2'b00;
      for (int i = 0; i < 8; i++) do_txn(tv[i]);
      req_dividend = {$urandom, $urandom};
      req_divisor = {$urandom, $urandom};
      req_valid = 2'b10;
      #1;
      chk("abort_grant", req_ready, 2'b10);
      tick();
      req_valid = 2'b00;
      repeat (5) tick();
      chk("abort_mid_busy", busy, 1);
      reset = 1;
      tick();
      reset = 0;
      chk("abort_busy", busy, 0);
      chk("abort_rsp_valid", rsp_valid, 2'b00);
      seen = 0;
      repeat (20) begin
         tick();
         if (rsp_valid != 2'b00) seen++;
      end
      chk("abort_no_rsp", seen, 0);
      for (int i = 8; i < 10; i++) do_txn(tv[i]);
      n = $urandom;
      d = $urandom;
      req_dividend_1 = {32'h0, n};
      req_divisor_1 = {32'h0, d};
      req_valid_1 = 2'b01;
      #1;
      chk("p1_grant", req_ready_1, 2'b01);
      tick();
      req_valid_1 = 2'b00;
      steps = 0;
      c_rsp = -1;
      for (int c = 1; c < 20 && c_rsp < 0; c++) begin
         if (dp_step_1) steps++;
         if (rsp_valid_1 != 2'b00) c_rsp = c;
         else tick();
      end
      chk("p1_rsp_cycle", c_rsp, 4);
      chk("p1_steps", steps, 1);
      chk("p1_rsp_owner", rsp_valid_1, 2'b01);
      chk("p1_quot", rsp_quotient_1, n ^ d);
      rsp_ready_1 = 2'b01;
      tick();
      rsp_ready_1 = 2'b00;
      chk("p1_post_busy", busy_1, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fpdiv_sched.md
# fpdiv_sched

Two-requester scheduler and sequencer for the shared iterative fp32 divider (`fpdiv` datapath). It arbitrates round-robin between two request ports with valid/ready handshakes and drives the datapath load, iteration-step and round strobes for a fixed number of Goldschmidt iterations. It captures the quotient and returns it to the owning requester.

## Interface
- `ITERS`, default 4: Goldschmidt iterations per divide (1..15).
- `MUL_LAT`, default 2: cycles per iteration (1..7).
- `clk`, in, 1: clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `req_valid`, in, 2: bit i set means requester i presents an operation.
- `req_ready`, out, 2: bit i set means the scheduler accepts requester i this cycle.
- `req_dividend`, in, 64: requester i operand in bits [32i+31:32i].
- `req_divisor`, in, 64: same packing as `req_dividend`.
- `req_round_mode`, in, 4: requester i mode in bits [2i+1:2i].
- `rsp_valid`, out, 2: one-hot; the result is for requester i.
- `rsp_ready`, in, 2: requester i accepts the result.
- `rsp_quotient`, out, 32: registered result.
- `busy`, out, 1: high in any state other than IDLE.
- `dp_load`, out, 1: load `dp_n`, `dp_d` and `dp_rm` into the datapath.
- `dp_n`, `dp_d`, out, 32 each: latched operands.
- `dp_rm`, out, 2: latched rounding mode.
- `dp_step`, out, 1: advance one iteration.
- `dp_round`, out, 1: final round/normalize.
- `dp_q`, in, 32: datapath quotient, combinationally valid in the ROUND cycle.

## Operation
- FSM states: IDLE, LOAD, ITER, ROUND, RESP.
- IDLE:
  - Grant requester g:
    - if only one `req_valid` bit is set, g is that requester;
    - if both are set, g is the requester that is not `last_grant`.
  - `req_ready[g]` is 1, combinational from `req_valid` and `last_grant`. The other `req_ready` bit is 0.
  - On `req_valid[g] & req_ready[g]`:
    - latch operands and mode into `dp_n`, `dp_d`, `dp_rm`;
    - set `owner <= g`;
    - go to LOAD.
- LOAD: `dp_load`=1 for one cycle. Clear `cyc` and `iter`, then go to ITER.
- ITER:
  - `dp_step`=1 when `cyc`==0, then `cyc` increments.
  - When `cyc`==MUL_LAT-1: set `cyc` to 0 and increment `iter`.
  - When `iter` reaches ITERS-1 and `cyc` reaches MUL_LAT-1, go to ROUND.
  - Exactly ITERS `dp_step` pulses occur, MUL_LAT cycles apart.
- ROUND: `dp_round`=1 for one cycle. Set `rsp_quotient <= dp_q`, then go to RESP.
- RESP:
  - `rsp_valid[owner]`=1; hold it and `rsp_quotient` stable until `rsp_ready[owner]`.
  - `rsp_ready` of the non-owner is ignored.
  - On the handshake: set `last_grant <= owner` and go to IDLE.
- `req_ready` is 0 in every state except IDLE. Requests are not accepted during RESP.
- Counter widths: `cyc` 3 bits, `iter` 4 bits. Neither counter wraps within a divide.
- The scheduler never inspects operand values; NaN, zero and subnormal handling belongs to the datapath.

## Timing
- Reset values:
  - state IDLE, `last_grant`=1 (requester 0 wins the first tie);
  - `rsp_valid`=0, `rsp_quotient`=0, `busy`=0;
  - all `dp_*` strobes 0, `dp_n`=`dp_d`=0, `dp_rm`=0, `owner`=0.
- Latency, with the accept edge as cycle 0:
  - LOAD in cycle 1;
  - ITER in cycles 2..1+ITERS*MUL_LAT;
  - ROUND in cycle 2+ITERS*MUL_LAT;
  - `rsp_valid` first high in cycle 3+ITERS*MUL_LAT (11 with defaults).
- Minimum spacing between accepts is 4+ITERS*MUL_LAT cycles (12 with defaults): one IDLE cycle always follows a response handshake.
- `dp_step` pulses occur in cycles 2, 2+MUL_LAT, …, 2+(ITERS-1)*MUL_LAT.
- Reset asserted mid-divide or mid-RESP:
  - return to IDLE next edge;
  - the transaction is dropped and no response is issued;
  - `rsp_valid` is 0 in the cycle after the reset edge.
- `req_valid` deasserted in the grant cycle: no accept, and the grant is re-evaluated next cycle.

## Test plan
- Single request from requester 0:
  - stimulus: N=0x40400000, D=0x40000000, rm=00; stub `dp_q`=0x3FC00000;
  - required: `dp_load` in cycle 1; `dp_step` in cycles 2,4,6,8; `dp_round` in cycle 10; `rsp_valid`=01 with 0x3FC00000 in cycle 11.
- Both requesters valid at reset release:
  - required: requester 0 granted first, then requester 1 after the response handshake;
  - continuous requests alternate 0,1,0,1 with accepts 12 cycles apart.
- Backpressure:
  - stimulus: `rsp_ready[owner]`=0 for 5 cycles after `rsp_valid` rises;
  - required: `rsp_valid` and `rsp_quotient` stable for all 5 cycles, `req_ready`=00 throughout, `rsp_ready` of the non-owner ignored.
- Reset pulse in cycle 6 of a divide:
  - required: IDLE and `busy`=0 next cycle, no `rsp_valid` pulse;
  - requester 0 wins the next tie.
- Parameter sweep ITERS=1, MUL_LAT=1:
  - required: `rsp_valid` in cycle 4 after accept, exactly one `dp_step` pulse.
